// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register file for the execute stage.
//   Commits ALU MULT products, services MTHI/MTLO/MFHI/MFLO and runs a
//   restoring iterative DIV/DIVU (one quotient bit per cycle, MSB first).
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   hilo_en           - qualifies hilo_control this cycle
//   hilo_control      - function code (alu_control encoding)
//   src_a, src_b      - rs (dividend / MT source), rt (divisor)
//   mult_hi, mult_lo  - ALU product halves committed on MULT
//   read_data         - HI on MFHI, LO on MFLO, otherwise 0 (combinational)
//   busy              - divide in flight (registered)
//   stall             - hilo request present but refused this cycle
//   div_by_zero       - one-cycle pulse after a DIV/DIVU with src_b == 0
module hilo_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CONTROL_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hilo_en,
  input  logic [CONTROL_WIDTH-1:0] hilo_control,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic [DATA_WIDTH-1:0]    mult_hi,
  input  logic [DATA_WIDTH-1:0]    mult_lo,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     busy,
  output logic                     stall,
  output logic                     div_by_zero
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  localparam logic [CONTROL_WIDTH-1:0] OP_MFHI = CONTROL_WIDTH'(6'b010000);
  localparam logic [CONTROL_WIDTH-1:0] OP_MTHI = CONTROL_WIDTH'(6'b010001);
  localparam logic [CONTROL_WIDTH-1:0] OP_MFLO = CONTROL_WIDTH'(6'b010010);
  localparam logic [CONTROL_WIDTH-1:0] OP_MTLO = CONTROL_WIDTH'(6'b010011);
  localparam logic [CONTROL_WIDTH-1:0] OP_MULT = CONTROL_WIDTH'(6'b011000);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIV  = CONTROL_WIDTH'(6'b011010);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVU = CONTROL_WIDTH'(6'b011011);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] hi, lo;
  logic [DATA_WIDTH-1:0] dvsr;     // divisor magnitude
  logic [DATA_WIDTH-1:0] quo;      // dividend shifts out MSB-first, quotient shifts in
  logic [DATA_WIDTH:0]   rem;      // partial remainder
  logic [CNT_W-1:0]      cnt;
  logic                  neg_q, neg_r;

  logic                  is_hilo_op, accept, is_div, div_zero, div_start;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH+1:0] trial_diff;
  logic                  step_ge;
  logic [DATA_WIDTH:0]   rem_step;
  logic [DATA_WIDTH-1:0] quo_step, q_final, r_final;

  // ---------------- request decode ----------------
  always_comb begin
    is_hilo_op = hilo_control inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                                      OP_MULT, OP_DIV, OP_DIVU};
    stall      = hilo_en & busy & is_hilo_op;
    accept     = hilo_en & ~stall & is_hilo_op;
    is_div     = (hilo_control == OP_DIV) | (hilo_control == OP_DIVU);
    div_zero   = (src_b == '0);
    div_start  = accept & is_div & ~div_zero;
  end

  always_comb begin
    read_data = '0;
    if (hilo_en && !stall) begin
      if (hilo_control == OP_MFHI) read_data = hi;
      else if (hilo_control == OP_MFLO) read_data = lo;
    end
  end

  // ---------------- divide datapath ----------------
  always_comb begin
    a_neg = (hilo_control == OP_DIV) & src_a[DATA_WIDTH-1];
    b_neg = (hilo_control == OP_DIV) & src_b[DATA_WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  // Trial subtraction is done one bit wider than the shifted remainder so
  // the borrow (MSB) directly tells whether the divisor fits.
  always_comb begin
    trial_diff = {rem, quo[DATA_WIDTH-1]} - {2'b00, dvsr};
    step_ge    = ~trial_diff[DATA_WIDTH+1];
    rem_step   = step_ge ? trial_diff[DATA_WIDTH:0]
                         : {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
    quo_step   = {quo[DATA_WIDTH-2:0], step_ge};
    q_final    = neg_q ? -quo : quo;
    r_final    = neg_r ? -rem[DATA_WIDTH-1:0] : rem[DATA_WIDTH-1:0];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_start) state_d = S_RUN;
      S_RUN:   if (cnt == LAST_STEP) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dvsr        <= '0;
      quo         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      div_by_zero <= accept & is_div & div_zero;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (hilo_control)
              OP_MULT: begin
                hi <= mult_hi;
                lo <= mult_lo;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                  dvsr  <= b_mag;
                  quo   <= a_mag;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  busy  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          lo   <= q_final;
          hi   <= r_final;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed plus randomized checks of hilo_unit against a
// behavioural HI/LO model (64-bit integer division for DIV/DIVU).
module tb_hilo_unit;

  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MTHI = 6'b010001;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_MTLO = 6'b010011;
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic        hilo_en;
  logic [5:0]  hilo_control;
  logic [31:0] src_a, src_b, mult_hi, mult_lo;
  logic [31:0] read_data;
  logic        busy, stall, div_by_zero;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] hi_m, lo_m;
  int          exp_busy_cycles;

  always #5 clk = ~clk;

  hilo_unit #(.DATA_WIDTH(32), .CONTROL_WIDTH(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .hilo_en      (hilo_en),
    .hilo_control (hilo_control),
    .src_a        (src_a),
    .src_b        (src_b),
    .mult_hi      (mult_hi),
    .mult_lo      (mult_lo),
    .read_data    (read_data),
    .busy         (busy),
    .stall        (stall),
    .div_by_zero  (div_by_zero)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Signed divide done on 64-bit integers so the most-negative / -1 case
  // cannot overflow; C-style truncation gives the architectural results.
  task automatic div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint la, lb, lq, lr;
    la = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    lq = la / lb;
    lr = la % lb;
    q  = lq[31:0];
    r  = lr[31:0];
  endtask

  task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] mh, input logic [31:0] ml);
    logic isdiv;
    logic [31:0] q, r;
    @(negedge clk);
    hilo_control = code; src_a = a; src_b = b; mult_hi = mh; mult_lo = ml;
    hilo_en = 1'b1;
    #1 check1("stall_on_issue", stall, 1'b0);
    @(posedge clk);
    #1 hilo_en = 1'b0;
    isdiv = (code == OP_DIV) || (code == OP_DIVU);
    check1("dbz_after_issue", div_by_zero, isdiv && (b == 32'h0));
    check1("busy_after_issue", busy, isdiv && (b != 32'h0));
    exp_busy_cycles = (isdiv && (b != 32'h0)) ? 33 : 0;
    case (code)
      OP_MULT: begin hi_m = mh; lo_m = ml; end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      OP_DIV, OP_DIVU: if (b != 32'h0) begin
        div_model(code == OP_DIV, a, b, q, r);
        lo_m = q; hi_m = r;
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkint("busy_cycles", n, exp_busy_cycles);
  endtask

  task automatic check_mf(input string tag);
    @(negedge clk);
    hilo_en = 1'b1;
    hilo_control = OP_MFHI;
    #1 check32({tag, "_mfhi"}, read_data, hi_m);
    hilo_control = OP_MFLO;
    #1 check32({tag, "_mflo"}, read_data, lo_m);
    check1({tag, "_stall"}, stall, 1'b0);
    hilo_en = 1'b0;
  endtask

  initial begin
    int stall_n;
    logic [5:0] code;
    logic [31:0] a, b;

    reset = 1'b1; hilo_en = 1'b0; hilo_control = '0;
    src_a = '0; src_b = '0; mult_hi = '0; mult_lo = '0;
    hi_m = '0; lo_m = '0; exp_busy_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_dbz", div_by_zero, 1'b0);
    check1("reset_stall", stall, 1'b0);
    @(negedge clk) reset = 1'b0;
    check_mf("reset");

    // MULT commit
    issue(OP_MULT, 32'h0, 32'h0, 32'h00000001, 32'h23456789);
    check_mf("mult");

    // MTHI / MTLO, then an unrecognised code changes nothing
    issue(OP_MTHI, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    issue(OP_MTLO, 32'h12345678, 32'h0, 32'h0, 32'h0);
    check_mf("mt");
    issue(6'h3F, 32'hFFFFFFFF, 32'h0, 32'hCAFEF00D, 32'hBADC0DE5);
    check_mf("unknown");

    // Signed and unsigned divide of -7 by 2
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0);
    wait_idle();
    check_mf("div_m7_2");
    check32("div_m7_2_const_lo", lo_m, 32'hFFFFFFFD);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0);
    wait_idle();
    check_mf("divu_m7_2");

    // MFLO held from 5 cycles into a divide: stalls until busy falls
    issue(OP_DIV, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    hilo_en = 1'b1; hilo_control = OP_MFLO;
    #1;
    stall_n = 0;
    for (int i = 0; i < 200 && stall; i++) begin
      check32("stalled_read_zero", read_data, 32'h0);
      stall_n++;
      @(negedge clk);
      #1;
    end
    checkint("mflo_stall_cycles", stall_n, 29);
    check32("mflo_after_div", read_data, 32'h0000000E);
    hilo_en = 1'b0;

    // Unknown code during busy does not stall; MTHI held through busy lands after
    issue(OP_DIV, 32'd1000, 32'd3, 32'h0, 32'h0);
    @(negedge clk);
    hilo_en = 1'b1; hilo_control = 6'h3F;
    #1 check1("unknown_no_stall", stall, 1'b0);
    hilo_control = OP_MTHI; src_a = 32'h5A5A5A5A;
    #1 check1("mthi_stalled", stall, 1'b1);
    for (int i = 0; i < 200 && stall; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 hilo_en = 1'b0;
    hi_m = 32'h5A5A5A5A;
    check_mf("mthi_held");

    // Divide by zero: pulse only, HI/LO untouched
    issue(OP_MTHI, 32'hAAAA0000, 32'h0, 32'h0, 32'h0);
    issue(OP_DIV, 32'd5, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 check1("dbz_one_cycle", div_by_zero, 1'b0);
    check1("dbz_no_busy", busy, 1'b0);
    check_mf("dbz");
    issue(OP_DIVU, 32'd9, 32'h0, 32'h0, 32'h0);
    check_mf("dbzu");

    // Most-negative / -1
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_idle();
    check_mf("div_ovf");

    // Asynchronous reset mid-divide at E10
    issue(OP_MULT, 32'h0, 32'h0, 32'h11111111, 32'h22222222);
    issue(OP_DIV, 32'd12345, 32'd17, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 check1("rst_mid_busy", busy, 1'b0);
    hilo_en = 1'b1; hilo_control = OP_MFHI;
    #1 check32("rst_mid_hi", read_data, 32'h0);
    hilo_control = OP_MFLO;
    #1 check32("rst_mid_lo", read_data, 32'h0);
    hilo_en = 1'b0;
    hi_m = '0; lo_m = '0;
    @(negedge clk) reset = 1'b0;
    check_mf("after_reset");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: code = OP_MULT;
        1: code = OP_MTHI;
        2: code = OP_MTLO;
        3, 4: code = OP_DIV;
        5: code = OP_DIVU;
        6: code = 6'h19;
        default: code = 6'h20;
      endcase
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      else if ($urandom_range(0, 2) == 0) b = b & 32'h0000001F;
      issue(code, a, b, $urandom, $urandom);
      wait_idle();
      check_mf("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream consumer of the ALU's 64-bit {result_hi,result_lo} output.
- Holds the architectural HI/LO registers and commits MULT products into them.
- Services MTHI/MTLO/MFHI/MFLO and runs a multi-cycle iterative DIV/DIVU.
- Sits in the execute stage beside the ALU and raises stall to the pipeline control while a divide is in flight.

Parameters:
DATA_WIDTH, 32, width of src_a/src_b/HI/LO; divide iteration count equals DATA_WIDTH
CONTROL_WIDTH, 6, width of the function-code input (same encoding as alu_control)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
hilo_en  input  1  qualifies hilo_control for this cycle
hilo_control  input  CONTROL_WIDTH  function code: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, DIV 011010, DIVU 011011
src_a  input  DATA_WIDTH  rs operand (dividend; MTHI/MTLO source)
src_b  input  DATA_WIDTH  rt operand (divisor)
mult_hi  input  DATA_WIDTH  ALU result_hi for the current MULT
mult_lo  input  DATA_WIDTH  ALU result_lo for the current MULT
read_data  output  DATA_WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)
busy  output  1  divide in progress (registered)
stall  output  1  request present but not accepted this cycle (combinational)
div_by_zero  output  1  one-cycle registered pulse when DIV/DIVU is issued with src_b==0

Behaviour:
- Reset (async, active-high):
  - hi=0, lo=0, busy=0, div_by_zero=0, state=IDLE, iteration counter=0.
  - Any divide in flight is aborted; its result is discarded.
- Hilo ops: the seven codes above. Any other code with hilo_en=1 is ignored: no state change, stall=0.
- stall = hilo_en & busy & (hilo_control is a hilo op).
  - A stalled request is not accepted. The producer holds it until stall=0.
- Accepted ops (hilo_en=1, stall=0), applied at the next rising edge:
  - MULT: hi<=mult_hi, lo<=mult_lo.
  - MTHI: hi<=src_a. MTLO: lo<=src_a.
  - MFHI/MFLO: no state change. read_data shows the current register in the same cycle.
  - MFHI/MFLO during busy stall; they never return a partial result.
- read_data is 0 whenever no MF op is presented or when stall=1.
- Divide FSM, states IDLE -> RUN -> FIX -> IDLE:
  - IDLE, DIV/DIVU accepted with src_b!=0 (edge E0):
    - Latch operand magnitudes: absolute values for DIV, raw values for DIVU.
    - Latch quotient-negate = sign(a)^sign(b) and remainder-negate = sign(a); both are 0 for DIVU.
    - Clear the partial remainder, set counter=0, busy<=1, go to RUN.
  - RUN: one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, counter++.
    - After DATA_WIDTH steps (edges E1..E32), go to FIX.
  - FIX (edge E33): lo<=quotient, hi<=remainder, each conditionally two's-complement negated; busy<=0; go to IDLE.
  - busy is high for exactly DATA_WIDTH+1 = 33 cycles. New HI/LO are visible in the cycle after E33.
  - A new request presented in the cycle busy falls is accepted normally.
- Divide by zero (src_b==0, DIV or DIVU):
  - HI/LO unchanged, busy stays 0, div_by_zero=1 for exactly one cycle after the accepting edge.
- Width and arithmetic rules:
  - Magnitudes are DATA_WIDTH-bit unsigned; the partial remainder is DATA_WIDTH+1 bits.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap, no flag.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- No overflow output. MULT correctness is the ALU's responsibility; this block only commits mult_hi/mult_lo.

Test Plan:
- Reset, then MFHI and MFLO -> read_data=0x00000000, busy=0, stall=0. Assert reset mid-divide at E10 -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
- MULT with mult_hi=0x00000001, mult_lo=0x23456789 -> next cycle MFHI returns 0x00000001 and MFLO returns 0x23456789.
- MTHI src_a=0xDEADBEEF, then MTLO src_a=0x12345678 -> MFHI=0xDEADBEEF, MFLO=0x12345678. Unknown code 0x3F with hilo_en=1 leaves both unchanged.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy high for 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- MFLO issued 5 cycles after DIV 100/7 -> stall=1 until busy falls, then read_data=0x0000000E. An MTHI held during busy is applied only after busy falls.
- DIV src_b=0 with hi=0xAAAA0000 -> single-cycle div_by_zero pulse, busy never asserts, hi still 0xAAAA0000. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
